// File: rtl/fdiv_prog.sv
// fdiv_prog: runtime-programmable clock-enable divider with square enable, period tick and beat count
module fdiv_prog #(
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 3750000,
  parameter int BEAT_W      = 8
) (
  input  logic              fin,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic [CNT_W-1:0]  div_in,
  input  logic              div_load,
  output logic              div_pend,
  output logic              fout,
  output logic              tick,
  output logic [BEAT_W-1:0] beat
);
  logic [CNT_W-1:0] count, n, pend_div, ne, n_nxt, ne_nxt, count_nxt;
  logic apply;
  always_comb begin
    ne        = (n == '0) ? CNT_W'(1) : n;
    apply     = en && !sync_clr && (div_pend || div_load) && (count >= ne || count == '0);
    n_nxt     = apply ? (div_load ? div_in : pend_div) : n;
    ne_nxt    = (n_nxt == '0) ? CNT_W'(1) : n_nxt;
    count_nxt = (count >= ne) ? CNT_W'(1) : count + CNT_W'(1);
  end
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      n        <= CNT_W'(DIV_DEFAULT);
      pend_div <= '0;
      div_pend <= 1'b0;
      fout     <= 1'b0;
      tick     <= 1'b0;
      beat     <= '0;
    end else begin
      n        <= n_nxt;
      pend_div <= div_load ? div_in : pend_div;
      div_pend <= !apply && (div_load || div_pend);
      if (sync_clr) begin
        count <= '0;
        fout  <= 1'b0;
        tick  <= 1'b0;
        beat  <= '0;
      end else if (en) begin
        count <= count_nxt;
        fout  <= count_nxt > (ne_nxt >> 1);
        tick  <= count_nxt == ne_nxt;
        beat  <= beat + BEAT_W'(count_nxt == ne_nxt);
      end else begin
        tick  <= 1'b0;
      end
    end
  end
endmodule
